// File: rtl/ref_mem_pkg.sv
// Shared types and helpers for the reference-memory bank controller.
package ref_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    PRIME   = 3'd2,
    SEARCH  = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // Number of preload groups for a given bank configuration.
  function automatic int num_groups(input int nb, input int bpg);
    return nb / bpg;
  endfunction

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ref_mem_ctrl_param_wr_addr_gen.sv
// Preload write-address generator: row/group counter pair, last-beat flag
// and the write-enable mask for the active bank group.
module ref_wr_addr_gen
  import ref_mem_pkg::*;
#(
  parameter int NUM_BANKS       = 32,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROWS_PER_BANK   = 96,
  parameter int ADDR_W          = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [ADDR_W-1:0]    o_row,
  output logic                 o_last,
  output logic [NUM_BANKS-1:0] o_mask
);

  localparam int NUM_GROUPS = num_groups(NUM_BANKS, BANKS_PER_GROUP);
  localparam int GRP_W      = cnt_w(NUM_GROUPS);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS_PER_BANK - 1);
  localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(NUM_GROUPS - 1);

  logic [ADDR_W-1:0]    r_row;
  logic [GRP_W-1:0]     r_grp;
  logic [NUM_BANKS-1:0] w_mask;

  // Row advances per accepted beat; wrapping the row steps to the next group.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_grp <= '0;
    end else if (i_adv) begin
      if (r_row == ROW_LAST) begin
        r_row <= '0;
        r_grp <= (r_grp == GRP_LAST) ? '0 : r_grp + 1'b1;
      end else begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  // Expand the group index into a contiguous run of bank enables.
  always_comb begin
    w_mask = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (r_grp == GRP_W'(g)) w_mask[g*BANKS_PER_GROUP +: BANKS_PER_GROUP] = '1;
    end
  end

  assign o_row  = r_row;
  assign o_mask = w_mask;
  assign o_last = (r_row == ROW_LAST) && (r_grp == GRP_LAST);

endmodule

// File: rtl/ref_mem_ctrl_param.sv
// Reference-memory bank controller: preloads the banked search window from
// the fetch stream, primes the PE array, then steps rows on PE request.
// Every output except o_in_ready is registered, so each action shows up on
// the cycle after the state that decided it.
module ref_mem_ctrl_param
  import ref_mem_pkg::*;
#(
  parameter int NUM_BANKS       = 32,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROWS_PER_BANK   = 96,
  parameter int ADDR_W          = 7,
  parameter int PRIME_ROWS      = 4,
  parameter int SEL_W           = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic                        i_step_req,
  output logic [NUM_BANKS-1:0]        o_bank_sel,
  output logic                        o_wr_en,
  output logic [NUM_BANKS*ADDR_W-1:0] o_wr_addr_all,
  output logic [ADDR_W-1:0]           o_rd_addr,
  output logic                        o_rd_en,
  output logic [SEL_W-1:0]            o_rd_sel,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam logic [ADDR_W-1:0] PRIME_LAST = ADDR_W'(PRIME_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(ROWS_PER_BANK - 1);

  state_t                      r_state, w_next;
  logic                        w_accept, w_last, w_clr;
  logic [ADDR_W-1:0]           w_row, r_cur, w_cur_inc;
  logic [NUM_BANKS-1:0]        w_mask;
  logic [NUM_BANKS-1:0]        r_bank_sel;
  logic                        r_wr_en, r_rd_en, r_busy, r_done;
  logic [NUM_BANKS*ADDR_W-1:0] r_wr_addr_all;
  logic [ADDR_W-1:0]           r_rd_addr;
  logic [SEL_W-1:0]            r_rd_sel;

  assign o_in_ready = (r_state == PRELOAD);
  assign w_accept   = o_in_ready && i_in_valid;
  assign w_clr      = (r_state == IDLE) || i_abort;
  assign w_cur_inc  = r_cur + 1'b1;

  ref_wr_addr_gen #(
    .NUM_BANKS      (NUM_BANKS),
    .BANKS_PER_GROUP(BANKS_PER_GROUP),
    .ROWS_PER_BANK  (ROWS_PER_BANK),
    .ADDR_W         (ADDR_W)
  ) u_wr_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_adv (w_accept && !i_abort),
    .o_row (w_row),
    .o_last(w_last),
    .o_mask(w_mask)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = PRELOAD;
      PRELOAD: if (w_accept && w_last) w_next = PRIME;
      PRIME:   if (r_cur == PRIME_LAST)
                 w_next = (PRIME_ROWS == ROWS_PER_BANK) ? FINISH : SEARCH;
      SEARCH:  if (i_step_req && (w_cur_inc == ROW_LAST)) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_abort) w_next = IDLE;
  end

  // Read row counter: walks the prime rows, then holds the last row read.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_cur <= '0;
    end else begin
      case (r_state)
        PRIME:   if (r_cur != PRIME_LAST) r_cur <= w_cur_inc;
        SEARCH:  if (i_step_req) r_cur <= w_cur_inc;
        default: r_cur <= '0;
      endcase
    end
  end

  // Registered RAM strobes and status; abort drops any in-flight write.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_wr_en       <= 1'b0;
      r_bank_sel    <= '0;
      r_wr_addr_all <= '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_sel      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_wr_en       <= w_accept;
      r_bank_sel    <= w_accept ? w_mask : '0;
      r_wr_addr_all <= w_accept ? {NUM_BANKS{w_row}} : '0;
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_rd_sel      <= '0;
      if (r_state == PRIME) begin
        r_rd_en   <= 1'b1;
        r_rd_addr <= r_cur;
        r_rd_sel  <= SEL_W'(PRIME_ROWS);
      end else if ((r_state == SEARCH) && i_step_req) begin
        r_rd_en   <= 1'b1;
        r_rd_addr <= w_cur_inc;
        r_rd_sel  <= SEL_W'(1);
      end
      r_busy <= (r_state != IDLE);
      r_done <= (r_state == FINISH);
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_bank_sel    = r_bank_sel;
  assign o_wr_addr_all = r_wr_addr_all;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr     = r_rd_addr;
  assign o_rd_sel      = r_rd_sel;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_ref_mem_ctrl_param.sv
// Bench for ref_mem_ctrl_param: default 32-bank instance plus a 16-bank
// instance where priming covers every row.
module tb_ref_mem_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration DUT.
  logic         rst, start, abort, in_valid, step_req;
  logic         in_ready, wr_en, rd_en, busy, done;
  logic [31:0]  bank_sel;
  logic [223:0] wr_addr_all;
  logic [6:0]   rd_addr;
  logic [3:0]   rd_sel;

  ref_mem_ctrl_param u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_step_req(step_req),
    .o_bank_sel(bank_sel), .o_wr_en(wr_en), .o_wr_addr_all(wr_addr_all),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .o_rd_sel(rd_sel),
    .o_busy(busy), .o_done(done)
  );

  // 16 banks, 8 per group, 8 rows, all rows primed.
  logic        b_rst, b_start, b_abort, b_in_valid, b_step_req;
  logic        b_in_ready, b_wr_en, b_rd_en, b_busy, b_done;
  logic [15:0] b_bank_sel;
  logic [47:0] b_wr_addr_all;
  logic [2:0]  b_rd_addr;
  logic [3:0]  b_rd_sel;

  ref_mem_ctrl_param #(
    .NUM_BANKS(16), .BANKS_PER_GROUP(8), .ROWS_PER_BANK(8),
    .ADDR_W(3), .PRIME_ROWS(8), .SEL_W(4)
  ) u_dut2 (
    .clk(clk), .rst(b_rst), .i_start(b_start), .i_abort(b_abort),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_step_req(b_step_req),
    .o_bank_sel(b_bank_sel), .o_wr_en(b_wr_en), .o_wr_addr_all(b_wr_addr_all),
    .o_rd_addr(b_rd_addr), .o_rd_en(b_rd_en), .o_rd_sel(b_rd_sel),
    .o_busy(b_busy), .o_done(b_done)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Activity log for the default DUT, sampled mid-cycle.
  logic [31:0] wsel [4096];
  logic [6:0]  waddr[4096];
  logic        wrep [4096];
  int          wcyc [4096];
  int          acyc [4096];
  logic [6:0]  raddr[256];
  logic [3:0]  rsel [256];
  int wn = 0, rn = 0, dn = 0, acc = 0, ovl = 0, last_rd_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (wr_en && rd_en) ovl <= ovl + 1;
    if (in_valid && in_ready) begin
      if (acc < 4096) acyc[acc] <= cyc;
      acc <= acc + 1;
    end
    if (wr_en) begin
      if (wn < 4096) begin
        wsel[wn]  <= bank_sel;
        waddr[wn] <= wr_addr_all[6:0];
        wrep[wn]  <= (wr_addr_all == {32{wr_addr_all[6:0]}});
        wcyc[wn]  <= cyc;
      end
      wn <= wn + 1;
    end
    if (rd_en) begin
      if (rn < 256) begin
        raddr[rn] <= rd_addr;
        rsel[rn]  <= rd_sel;
      end
      last_rd_cyc <= cyc;
      rn <= rn + 1;
    end
    if (done) begin
      dn <= dn + 1;
      done_cyc <= cyc;
    end
  end

  // Activity log for the 16-bank DUT.
  logic [15:0] b_wsel [64];
  logic [47:0] b_waddr[64];
  logic [2:0]  b_raddr[64];
  logic [3:0]  b_rsel [64];
  int b_wn = 0, b_rn = 0, b_dn = 0, b_ovl = 0, b_last_rd = 0, b_done_cyc = 0;

  always @(negedge clk) begin
    if (b_wr_en && b_rd_en) b_ovl <= b_ovl + 1;
    if (b_wr_en) begin
      if (b_wn < 64) begin
        b_wsel[b_wn]  <= b_bank_sel;
        b_waddr[b_wn] <= b_wr_addr_all;
      end
      b_wn <= b_wn + 1;
    end
    if (b_rd_en) begin
      if (b_rn < 64) begin
        b_raddr[b_rn] <= b_rd_addr;
        b_rsel[b_rn]  <= b_rd_sel;
      end
      b_last_rd <= cyc;
      b_rn <= b_rn + 1;
    end
    if (b_done) begin
      b_dn <= b_dn + 1;
      b_done_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bank_sel"}, bank_sel, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr_all"}, wr_addr_all, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_sel"}, rd_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Expected write k: group k/96 selects four banks, row k%96.
  task automatic check_writes(input string tag, input int base);
    int bad = 0;
    for (int k = 0; k < 768; k++) begin
      logic [31:0] em;
      logic [6:0]  ea;
      em = 32'hF << (4 * (k / 96));
      ea = 7'(k % 96);
      if (wsel[base+k] !== em || waddr[base+k] !== ea || wrep[base+k] !== 1'b1) bad++;
    end
    chk({tag, "_wr_seq_bad"}, bad, 0);
  endtask

  task automatic preload_until_prime(input string tag, input bit toggle);
    int budget = 4000;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    while (in_ready && budget > 0) begin
      if (toggle) in_valid = ~in_valid;
      tick();
      budget--;
    end
    chk({tag, "_preload_exit"}, in_ready, 0);
  endtask

  typedef struct {
    logic        rst, start, abort, in_valid, step_req;
    logic        e_wr_en;
    logic [31:0] e_sel;
    logic [6:0]  e_addr;
    logic        e_rd_en, e_busy, e_in_ready;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int wb, rb, ab, db, gap;

    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b0,1'b0};
    tbl[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b0,1'b1};
    tbl[3] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,32'hF,7'd0, 1'b0,1'b1,1'b1};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b1,1'b1};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,32'hF,7'd1, 1'b0,1'b1,1'b1};
    tbl[6] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,32'hF,7'd2, 1'b0,1'b1,1'b1};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b1,1'b1};
    tbl[8] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,32'h0,7'd0, 1'b0,1'b0,1'b0};

    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_step_req = 1'b0;

    // Reset, abort/start collision, start, stalled beats, abort mid-preload.
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      in_valid = tbl[i].in_valid; step_req = tbl[i].step_req;
      tick();
      b_rst = 1'b0;
      chk($sformatf("vec%0d_wr_en", i), wr_en, tbl[i].e_wr_en);
      chk($sformatf("vec%0d_bank_sel", i), bank_sel, tbl[i].e_sel);
      if (tbl[i].e_wr_en)
        chk($sformatf("vec%0d_wr_addr", i), wr_addr_all, {32{tbl[i].e_addr}});
      chk($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].e_rd_en);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, 1'b0);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_in_ready);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; step_req = 1'b0;
    tick();
    check_zero("after_abort");

    // Full preload with in_valid held high, then priming.
    wb = wn; rb = rn; db = dn;
    preload_until_prime("t1", 1'b0);
    repeat (8) tick();
    in_valid = 1'b0;
    chk("t1_wr_count", wn - wb, 768);
    check_writes("t1", wb);
    chk("t1_beat0_sel", wsel[wb], 32'h0000000F);
    chk("t1_beat0_addr", waddr[wb], 7'd0);
    chk("t1_beat96_sel", wsel[wb+96], 32'h000000F0);
    chk("t1_beat96_addr", waddr[wb+96], 7'd0);
    chk("t1_beat767_sel", wsel[wb+767], 32'hF0000000);
    chk("t1_beat767_addr", waddr[wb+767], 7'd95);
    chk("t1_prime_count", rn - rb, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_prime%0d_addr", i), raddr[rb+i], 7'(i));
      chk($sformatf("t1_prime%0d_sel", i), rsel[rb+i], 4'd4);
    end
    chk("t1_waiting_busy", busy, 1);
    chk("t1_no_done", dn - db, 0);

    // Step through the remaining rows with random gaps.
    rb = rn; db = dn;
    for (int i = 0; i < 92; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end
    repeat (4) tick();
    begin
      int bad = 0;
      for (int i = 0; i < 92; i++)
        if (raddr[rb+i] !== 7'(4 + i) || rsel[rb+i] !== 4'd1) bad++;
      chk("t3_step_seq_bad", bad, 0);
    end
    chk("t3_step_count", rn - rb, 92);
    chk("t3_last_addr", raddr[rb+91], 7'd95);
    chk("t3_done_count", dn - db, 1);
    chk("t3_done_after_last_read", done_cyc, last_rd_cyc + 1);
    chk("t3_idle_busy", busy, 0);

    // Preload with in_valid toggling every cycle.
    wb = wn; ab = acc;
    preload_until_prime("t2", 1'b1);
    in_valid = 1'b0;
    repeat (8) tick();
    chk("t2_wr_count", wn - wb, 768);
    chk("t2_acc_count", acc - ab, 768);
    check_writes("t2", wb);
    begin
      int bad = 0;
      for (int k = 0; k < 768; k++)
        if (wcyc[wb+k] != acyc[ab+k] + 1) bad++;
      chk("t2_wr_latency_bad", bad, 0);
    end

    // A few steps, then reset in the middle of the search.
    rb = rn;
    repeat (3) begin
      step_req = 1'b1; tick(); step_req = 1'b0; tick();
    end
    chk("t2_step_reads", rn - rb, 3);
    chk("t2_step_last_addr", raddr[rb+2], 7'd6);
    chk("t2_busy_search", busy, 1);
    rst = 1'b1;
    tick();
    check_zero("t2_rst");
    rst = 1'b0;
    wb = wn; rb = rn;
    step_req = 1'b1; in_valid = 1'b1;
    repeat (5) tick();
    step_req = 1'b0; in_valid = 1'b0;
    chk("t2_post_rst_writes", wn - wb, 0);
    chk("t2_post_rst_reads", rn - rb, 0);
    chk("t2_post_rst_busy", busy, 0);
    chk("t2_post_rst_ready", in_ready, 0);

    // Abort at beat 300, then a fresh start from group 0 row 0.
    ab = acc;
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    begin
      int budget = 1000;
      while ((acc - ab) < 300 && budget > 0) begin
        tick();
        budget--;
      end
    end
    chk("t4_beats_before_abort", acc - ab, 300);
    abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check_zero("t4_abort");
    tick();
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1;
    tick();
    chk("t4_restart_wr_en", wr_en, 1);
    chk("t4_restart_sel", bank_sel, 32'h0000000F);
    chk("t4_restart_addr0", wr_addr_all, 224'h0);
    tick();
    chk("t4_restart_addr1", wr_addr_all, {32{7'd1}});
    in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_no_overlap", ovl, 0);

    // 16-bank configuration: priming covers every row, no search phase.
    b_start = 1'b1; b_in_valid = 1'b1;
    tick();
    b_start = 1'b0;
    begin
      int budget = 100;
      while (b_in_ready && budget > 0) begin
        tick();
        budget--;
      end
    end
    chk("t5_preload_exit", b_in_ready, 0);
    repeat (12) tick();
    b_in_valid = 1'b0;
    chk("t5_wr_count", b_wn, 16);
    begin
      int bad = 0;
      for (int k = 0; k < 16; k++) begin
        logic [15:0] em;
        em = (k < 8) ? 16'h00FF : 16'hFF00;
        if (b_wsel[k] !== em || b_waddr[k] !== {16{3'(k % 8)}}) bad++;
      end
      chk("t5_wr_seq_bad", bad, 0);
    end
    chk("t5_sel_first", b_wsel[0], 16'h00FF);
    chk("t5_sel_last", b_wsel[15], 16'hFF00);
    chk("t5_rd_count", b_rn, 8);
    begin
      int bad = 0;
      for (int i = 0; i < 8; i++)
        if (b_raddr[i] !== 3'(i) || b_rsel[i] !== 4'd8) bad++;
      chk("t5_rd_seq_bad", bad, 0);
    end
    chk("t5_done_count", b_dn, 1);
    chk("t5_done_after_last_read", b_done_cyc, b_last_rd + 1);
    chk("t5_idle_busy", b_busy, 0);
    chk("t5_no_overlap", b_ovl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ref_mem_ctrl_param.md
Name: ref_mem_ctrl_param

Overview:
Parametrised successor to the reference-memory bank controller for the DMT motion-estimation array. It preloads the banked reference search window group-by-group from an upstream fetch stream using a valid/ready handshake, primes the PE array with the first rows, then steps row reads on PE request. Reset and abort return it to a clean idle state. It sits between the external reference fetch unit and the 32-bank reference RAM / PE array.

Parameters:
NUM_BANKS, 32, number of reference RAM banks.
BANKS_PER_GROUP, 4, banks written together per preload group; NUM_BANKS % BANKS_PER_GROUP == 0.
ROWS_PER_BANK, 96, rows per bank written during preload; must be <= 2**ADDR_W.
ADDR_W, 7, bank address width.
PRIME_ROWS, 4, rows read during priming; 1 <= PRIME_ROWS <= ROWS_PER_BANK.
SEL_W, 4, width of rd_sel; PRIME_ROWS < 2**SEL_W.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; starts a preload; honoured only in IDLE.
abort  in  1  returns to IDLE from any state; takes priority over all other inputs except rst.
in_valid  in  1  upstream beat valid; one beat = one row for the current group.
in_ready  out  1  high only in PRELOAD.
step_req  in  1  PE request for the next row; honoured only in SEARCH.
bank_sel  out  NUM_BANKS  write-enable mask for the current group.
wr_en  out  1  write strobe.
wr_addr_all  out  NUM_BANKS*ADDR_W  write row address, replicated per bank.
rd_addr  out  ADDR_W  read row address broadcast to all banks.
rd_en  out  1  read strobe, active-high.
rd_sel  out  SEL_W  rows delivered per read burst: PRIME_ROWS when priming, 1 when stepping.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including bank_sel, wr_en, wr_addr_all, rd_addr, rd_en, rd_sel, busy, done and in_ready. Counters are cleared.
- All outputs are registered except in_ready, which is decoded from the state.
- FSM states: IDLE, PRELOAD, PRIME, SEARCH, FINISH.
- IDLE:
  - start -> PRELOAD.
  - pre_cnt=0.
- PRELOAD:
  - A beat is accepted when in_valid & in_ready.
  - Write decode: group g = pre_cnt / ROWS_PER_BANK; row r = pre_cnt % ROWS_PER_BANK.
  - Write outputs, registered one cycle after acceptance: wr_en=1; bank_sel = banks g*BPG .. g*BPG+BPG-1 set; wr_addr_all = {NUM_BANKS{r}}.
  - A cycle with no accepted beat gives wr_en=0 and bank_sel=0 (stall).
  - Implement group and row as two counters (row wraps at ROWS_PER_BANK-1, then group increments). No divider.
  - Transition: the last beat (g=NUM_GROUPS-1, r=ROWS_PER_BANK-1) is accepted -> PRIME. That write still appears on the next cycle.
- PRIME:
  - One cycle per read: rd_en=1, rd_addr=0..PRIME_ROWS-1 consecutively, rd_sel=PRIME_ROWS.
  - No stalls.
  - After the read at PRIME_ROWS-1 -> SEARCH, with cur_row=PRIME_ROWS-1.
- SEARCH:
  - rd_en=0 by default.
  - step_req: cur_row += 1; next cycle rd_en=1, rd_addr=cur_row, rd_sel=1.
  - When the read of ROWS_PER_BANK-1 is issued -> FINISH.
  - Edge case: if PRIME_ROWS==ROWS_PER_BANK, PRIME goes straight to FINISH.
- FINISH:
  - done=1 for one cycle, then IDLE.
  - rd_en and wr_en are 0.
- abort: next cycle state=IDLE and all outputs take their reset values. Any in-flight write is dropped.
- Simultaneous events:
  - abort and start in IDLE -> stay IDLE.
  - start outside IDLE is ignored.
  - step_req outside SEARCH is ignored (not queued).
  - in_valid outside PRELOAD is not accepted.
- Write and read never overlap: wr_en and rd_en are never high in the same cycle.

Decomposition:
- Package ref_mem_pkg holds:
  - the state enum (IDLE/PRELOAD/PRIME/SEARCH/FINISH);
  - derived constant NUM_GROUPS = NUM_BANKS/BANKS_PER_GROUP;
  - a clog2-based width helper for the group counter.
- One sub-module, ref_wr_addr_gen, provides:
  - the group/row counter pair with advance and clear;
  - the last-beat flag;
  - the group one-hot mask generation.

Test Plan:
- Defaults, start, in_valid held high -> 768 writes. Beat 0 gives bank_sel=0x0000000F, addr 0. Beat 96 gives bank_sel=0x000000F0, addr 0. Beat 767 gives bank_sel=0xF0000000, addr 95. Then 4 reads at rd_addr 0..3 with rd_sel=4.
- in_valid toggling 1/0 every cycle in PRELOAD -> wr_en follows the accepted beats with one-cycle latency. Same 768 writes, row/group sequence unchanged.
- After priming, 92 step_req pulses with random gaps -> rd_addr 4..95, rd_sel=1. done pulses once after the read of address 95, then busy=0.
- abort asserted at beat 300 -> next cycle IDLE with all outputs 0. A fresh start restarts at bank_sel=0x0000000F, addr 0.
- rst asserted mid-SEARCH -> all outputs 0 on the next edge. step_req and in_valid are ignored until a new start.
- NUM_BANKS=16, BANKS_PER_GROUP=8, ROWS_PER_BANK=8, PRIME_ROWS=8 -> 16 writes with masks 0x00FF then 0xFF00. 8 prime reads at addr 0..7, then done with no SEARCH phase.
